// File: rtl/snitch_ro_line_cache_mp.sv
// rtl/snitch_ro_line_cache_mp.sv - multi-port read-only line cache with round-robin grant, hit service and line refill
module snitch_ro_line_cache_mp #(
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned LineWidth   = 128,
    parameter int unsigned LineCount   = 16,
    parameter int unsigned NrAddrRules = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             flush_valid_i,
    output logic                             flush_ready_o,
    input  logic [NrAddrRules*AddrWidth-1:0] start_addr_i,
    input  logic [NrAddrRules*AddrWidth-1:0] end_addr_i,
    input  logic [NrPorts-1:0]               req_valid_i,
    output logic [NrPorts-1:0]               req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0]     req_addr_i,
    output logic [NrPorts-1:0]               rsp_valid_o,
    input  logic [NrPorts-1:0]               rsp_ready_i,
    output logic [DataWidth-1:0]             rsp_data_o,
    output logic                             rsp_error_o,
    output logic                             refill_req_valid_o,
    input  logic                             refill_req_ready_i,
    output logic [AddrWidth-1:0]             refill_req_addr_o,
    output logic                             refill_req_bypass_o,
    input  logic                             refill_rsp_valid_i,
    output logic                             refill_rsp_ready_o,
    input  logic [LineWidth-1:0]             refill_rsp_data_i,
    input  logic                             refill_rsp_error_i
);
    localparam int unsigned WA  = $clog2(DataWidth / 8);
    localparam int unsigned LA  = $clog2(LineWidth / 8);
    localparam int unsigned IA  = $clog2(LineCount);
    localparam int unsigned TW  = AddrWidth - LA - IA;
    localparam int unsigned WPL = LineWidth / DataWidth;
    localparam int unsigned OW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int unsigned PW  = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    typedef enum logic [2:0] {IDLE, RESP, REFILL_REQ, REFILL_WAIT, FLUSH} state_e;

    function automatic logic [OW-1:0] addr_off(input logic [AddrWidth-1:0] a);
        return (WPL > 1) ? OW'(a >> WA) : '0;
    endfunction

    function automatic logic [IA-1:0] addr_idx(input logic [AddrWidth-1:0] a);
        return IA'(a >> LA);
    endfunction

    function automatic logic [TW-1:0] addr_tag(input logic [AddrWidth-1:0] a);
        return TW'(a >> (LA + IA));
    endfunction

    function automatic logic [DataWidth-1:0] line_word(input logic [LineWidth-1:0] l,
                                                       input logic [OW-1:0]        o);
        return l[o*DataWidth +: DataWidth];
    endfunction

    state_e                 state_q;
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          gnt_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   bypass_q;
    logic [DataWidth-1:0]   rsp_data_q;
    logic                   rsp_error_q;
    logic [NrPorts-1:0]     rsp_valid_q;
    logic                   refill_req_valid_q;
    logic                   refill_rsp_ready_q;
    logic                   flush_ready_q;
    logic [LineCount-1:0]   valid_q;
    logic [TW-1:0]          tag_q  [LineCount];
    logic [LineWidth-1:0]   data_q [LineCount];

    logic                   grant_valid;
    logic [PW-1:0]          grant_idx;
    logic [NrPorts-1:0]     grant_oh;
    logic [AddrWidth-1:0]   acc_addr;
    logic                   acc_cacheable;
    logic                   acc_hit;
    logic                   line_we;
    int                     cand;

    // First requesting port at or after the round-robin pointer; scanning
    // downwards lets the nearest candidate overwrite the farther ones.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr_q) + i) % int'(NrPorts);
            if (req_valid_i[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign grant_oh = NrPorts'(1) << grant_idx;
    assign acc_addr = req_addr_i[grant_idx*AddrWidth +: AddrWidth];

    // An inverted or degenerate rule (start >= end) can never match.
    always_comb begin
        acc_cacheable = 1'b0;
        for (int r = 0; r < int'(NrAddrRules); r++) begin
            if (acc_addr >= start_addr_i[r*AddrWidth +: AddrWidth] &&
                acc_addr <  end_addr_i[r*AddrWidth +: AddrWidth]) begin
                acc_cacheable = 1'b1;
            end
        end
        acc_cacheable = acc_cacheable & enable_i;
    end

    assign acc_hit = acc_cacheable && valid_q[addr_idx(acc_addr)] &&
                     (tag_q[addr_idx(acc_addr)] == addr_tag(acc_addr));

    assign req_ready_o = (state_q == IDLE && !flush_valid_i && grant_valid) ? grant_oh : '0;

    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_data_o          = rsp_data_q;
    assign rsp_error_o         = rsp_error_q;
    assign refill_req_valid_o  = refill_req_valid_q;
    assign refill_req_addr_o   = {addr_q[AddrWidth-1:LA], LA'(0)};
    assign refill_req_bypass_o = bypass_q;
    assign refill_rsp_ready_o  = refill_rsp_ready_q;
    assign flush_ready_o       = flush_ready_q;

    assign line_we = !rst_i && state_q == REFILL_WAIT && refill_rsp_valid_i &&
                     !bypass_q && !refill_rsp_error_i;

    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[addr_idx(addr_q)]  <= addr_tag(addr_q);
            data_q[addr_idx(addr_q)] <= refill_rsp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= IDLE;
            rr_ptr_q           <= '0;
            gnt_q              <= '0;
            addr_q             <= '0;
            bypass_q           <= 1'b0;
            rsp_data_q         <= '0;
            rsp_error_q        <= 1'b0;
            rsp_valid_q        <= '0;
            refill_req_valid_q <= 1'b0;
            refill_rsp_ready_q <= 1'b0;
            flush_ready_q      <= 1'b0;
            valid_q            <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_valid_i) begin
                        state_q       <= FLUSH;
                        flush_ready_q <= 1'b1;
                    end else if (grant_valid) begin
                        gnt_q    <= grant_idx;
                        rr_ptr_q <= PW'((int'(grant_idx) + 1) % int'(NrPorts));
                        addr_q   <= acc_addr;
                        bypass_q <= !acc_cacheable;
                        if (acc_hit) begin
                            rsp_data_q  <= line_word(data_q[addr_idx(acc_addr)], addr_off(acc_addr));
                            rsp_error_q <= 1'b0;
                            rsp_valid_q <= grant_oh;
                            state_q     <= RESP;
                        end else begin
                            refill_req_valid_q <= 1'b1;
                            state_q            <= REFILL_REQ;
                        end
                    end
                end
                REFILL_REQ: begin
                    if (refill_req_ready_i) begin
                        refill_req_valid_q <= 1'b0;
                        refill_rsp_ready_q <= 1'b1;
                        state_q            <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (refill_rsp_valid_i) begin
                        refill_rsp_ready_q <= 1'b0;
                        rsp_data_q         <= line_word(refill_rsp_data_i, addr_off(addr_q));
                        rsp_error_q        <= refill_rsp_error_i;
                        rsp_valid_q        <= NrPorts'(1) << gnt_q;
                        state_q            <= RESP;
                        // A failed refill leaves the slot invalid so the next access retries.
                        if (!bypass_q) begin
                            valid_q[addr_idx(addr_q)] <= !refill_rsp_error_i;
                        end
                    end
                end
                RESP: begin
                    if (|(rsp_valid_q & rsp_ready_i)) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                FLUSH: begin
                    valid_q       <= '0;
                    flush_ready_q <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snitch_ro_line_cache_mp.sv
// tb/tb_snitch_ro_line_cache_mp.sv - scoreboard bench for snitch_ro_line_cache_mp
module tb_snitch_ro_line_cache_mp;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 128;
    localparam int LC = 16;
    localparam int NR = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_i;
    logic             flush_valid_i;
    logic             flush_ready_o;
    logic [NR*AW-1:0] start_addr_i;
    logic [NR*AW-1:0] end_addr_i;
    logic [NP-1:0]    req_valid_i;
    logic [NP-1:0]    req_ready_o;
    logic [NP*AW-1:0] req_addr_i;
    logic [NP-1:0]    rsp_valid_o;
    logic [NP-1:0]    rsp_ready_i;
    logic [DW-1:0]    rsp_data_o;
    logic             rsp_error_o;
    logic             refill_req_valid_o;
    logic             refill_req_ready_i;
    logic [AW-1:0]    refill_req_addr_o;
    logic             refill_req_bypass_o;
    logic             refill_rsp_valid_i;
    logic             refill_rsp_ready_o;
    logic [LW-1:0]    refill_rsp_data_i;
    logic             refill_rsp_error_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] req_q [NP][$];
    exp_t        exp_q [NP][$];
    logic [32:0] refill_log [$];
    int          grant_log [$];
    int          acc_cyc [NP];
    int          rsp_cyc [NP];
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    snitch_ro_line_cache_mp #(
        .NrPorts(NP), .AddrWidth(AW), .DataWidth(DW),
        .LineWidth(LW), .LineCount(LC), .NrAddrRules(NR)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .enable_i            (enable_i),
        .flush_valid_i       (flush_valid_i),
        .flush_ready_o       (flush_ready_o),
        .start_addr_i        (start_addr_i),
        .end_addr_i          (end_addr_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_addr_i          (req_addr_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_data_o          (rsp_data_o),
        .rsp_error_o         (rsp_error_o),
        .refill_req_valid_o  (refill_req_valid_o),
        .refill_req_ready_i  (refill_req_ready_i),
        .refill_req_addr_o   (refill_req_addr_o),
        .refill_req_bypass_o (refill_req_bypass_o),
        .refill_rsp_valid_i  (refill_rsp_valid_i),
        .refill_rsp_ready_o  (refill_rsp_ready_o),
        .refill_rsp_data_i   (refill_rsp_data_i),
        .refill_rsp_error_i  (refill_rsp_error_i)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [LW-1:0] line_of(input logic [31:0] a);
        logic [LW-1:0] l;
        l = '0;
        if (a == 32'h1000) begin
            l = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        end else begin
            for (int k = 0; k < 4; k++) l[k*32 +: 32] = (a ^ 32'h5A00_0000) + 32'(k);
        end
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [LW-1:0] l;
        l = line_of({a[31:4], 4'h0});
        return l[a[3:2]*32 +: 32];
    endfunction

    task automatic push_read(input int p, input logic [31:0] a, input logic err);
        exp_t e;
        e.data = word_of(a);
        e.err  = err;
        exp_q[p].push_back(e);
        req_q[p].push_back(a);
    endtask

    task automatic drain();
        int n = 0;
        while ((req_q[0].size() + req_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d, required 0",
                     req_q[0].size() + req_q[1].size() + exp_q[0].size() + exp_q[1].size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Request driver: head of each port queue is presented until accepted.
    initial begin
        req_valid_i = '0;
        req_addr_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (req_q[p].size() > 0) begin
                    req_valid_i[p]         = 1'b1;
                    req_addr_i[p*AW +: AW] = req_q[p][0];
                end else begin
                    req_valid_i[p] = 1'b0;
                end
            end
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (req_valid_i[p] && req_ready_o[p]) begin
                    void'(req_q[p].pop_front());
                    grant_log.push_back(p);
                    acc_cyc[p] = cyc;
                end
            end
        end
    end

    // Refill memory model: ready is withheld one cycle to observe request hold.
    initial begin
        logic [31:0] a;
        logic        b;
        int          n;
        refill_req_ready_i = 1'b0;
        refill_rsp_valid_i = 1'b0;
        refill_rsp_data_i  = '0;
        refill_rsp_error_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && refill_req_valid_o) begin
                a = refill_req_addr_o;
                b = refill_req_bypass_o;
                @(posedge clk);
                #1 refill_req_ready_i = 1'b1;
                @(negedge clk);
                n_checks++;
                if (refill_req_valid_o !== 1'b1 || refill_req_addr_o !== a || refill_req_bypass_o !== b) begin
                    n_fail++;
                    $display("FAIL refill_req_hold: valid=%0b addr=%h bypass=%0b, required 1 %h %0b",
                             refill_req_valid_o, refill_req_addr_o, refill_req_bypass_o, a, b);
                end
                @(posedge clk);
                #1 refill_req_ready_i = 1'b0;
                refill_log.push_back({b, a});
                refill_rsp_valid_i = 1'b1;
                refill_rsp_data_i  = line_of(a);
                refill_rsp_error_i = (a == err_addr);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!refill_rsp_ready_o && n < 50);
                if (!refill_rsp_ready_o) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL refill_rsp_ready_timeout: ready=%0b, required 1", refill_rsp_ready_o);
                end
                @(posedge clk);
                #1 refill_rsp_valid_i = 1'b0;
                refill_rsp_error_i = 1'b0;
            end
        end
    end

    // Response monitor: pops the per-port scoreboard on every handshake.
    initial begin
        logic [NP-1:0] prev;
        exp_t          e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid_o != '0) begin
                    n_checks++;
                    if (!$onehot(rsp_valid_o)) begin
                        n_fail++;
                        $display("FAIL rsp_valid_onehot: rsp_valid=%b, required one-hot", rsp_valid_o);
                    end
                end
                for (int p = 0; p < NP; p++) begin
                    if (rsp_valid_o[p] && !prev[p]) rsp_cyc[p] = cyc;
                    if (rsp_valid_o[p] && rsp_ready_i[p]) begin
                        n_checks++;
                        if (exp_q[p].size() == 0) begin
                            n_fail++;
                            $display("FAIL rsp_unexpected port%0d: data=%h, required no response", p, rsp_data_o);
                        end else begin
                            e = exp_q[p].pop_front();
                            if (rsp_data_o !== e.data || rsp_error_o !== e.err) begin
                                n_fail++;
                                $display("FAIL rsp_port%0d: data=%h err=%0b, required %h %0b",
                                         p, rsp_data_o, rsp_error_o, e.data, e.err);
                            end
                        end
                    end
                end
            end
            prev = rsp_valid_o;
        end
    end

    task automatic test_reset();
        rst           = 1'b1;
        enable_i      = 1'b1;
        flush_valid_i = 1'b0;
        rsp_ready_i   = '1;
        start_addr_i  = {32'h0000_3000, 32'h0000_1000};
        end_addr_i    = {32'h0000_3000, 32'h0000_2000};
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready_o !== '0 || rsp_valid_o !== '0) begin
            n_fail++;
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, required 00 00", req_ready_o, rsp_valid_o);
        end
        n_checks++;
        if (refill_req_valid_o !== 1'b0 || refill_rsp_ready_o !== 1'b0 || flush_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: refill_req_valid=%0b refill_rsp_ready=%0b flush_ready=%0b, required 0 0 0",
                     refill_req_valid_o, refill_rsp_ready_o, flush_ready_o);
        end
        n_checks++;
        if (rsp_data_o !== '0 || rsp_error_o !== 1'b0 || refill_req_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rsp_data=%h err=%0b refill_addr=%h, required 0 0 0",
                     rsp_data_o, rsp_error_o, refill_req_addr_o);
        end
    endtask

    task automatic test_refill_hit();
        refill_log.delete();
        push_read(0, 32'h1004, 1'b0);
        drain();
        n_checks++;
        if (refill_log.size() != 1 || refill_log[0] !== {1'b0, 32'h1000}) begin
            n_fail++;
            $display("FAIL miss_refill: count=%0d first=%h, required 1 %h",
                     refill_log.size(), (refill_log.size() > 0) ? refill_log[0] : 33'h0, {1'b0, 32'h1000});
        end
        refill_log.delete();
        push_read(0, 32'h1008, 1'b0);
        drain();
        n_checks++;
        if (refill_log.size() != 0) begin
            n_fail++;
            $display("FAIL hit_no_refill: refills=%0d, required 0", refill_log.size());
        end
        n_checks++;
        if (rsp_cyc[0] - acc_cyc[0] != 1) begin
            n_fail++;
            $display("FAIL hit_latency: cycles=%0d, required 1", rsp_cyc[0] - acc_cyc[0]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] addrs [5] = '{32'h3000, 32'h3000, 32'h2000, 32'h1FFC, 32'h1004};
        int          ports [5] = '{0, 0, 0, 0, 1};
        logic        ens   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        byps  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [32:0] want;
        for (int i = 0; i < 5; i++) begin
            enable_i = ens[i];
            refill_log.delete();
            push_read(ports[i], addrs[i], 1'b0);
            drain();
            want = {byps[i], addrs[i][31:4], 4'h0};
            n_checks++;
            if (refill_log.size() != 1 || refill_log[0] !== want) begin
                n_fail++;
                $display("FAIL bypass_refill[%0d]: count=%0d first=%h, required 1 %h",
                         i, refill_log.size(), (refill_log.size() > 0) ? refill_log[0] : 33'h0, want);
            end
        end
        enable_i = 1'b1;
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        refill_log.delete();
        grant_log.delete();
        push_read(0, 32'h1000, 1'b0);
        push_read(0, 32'h1008, 1'b0);
        push_read(1, 32'h1004, 1'b0);
        push_read(1, 32'h100C, 1'b0);
        drain();
        n_checks++;
        if (grant_log.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: grants=%0d, required 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grant_log[i] != i % 2) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: port=%0d, required %0d", i, grant_log[i], i % 2);
                end
            end
        end
        n_checks++;
        if (refill_log.size() != 0) begin
            n_fail++;
            $display("FAIL rr_all_hits: refills=%0d, required 0", refill_log.size());
        end
    endtask

    task automatic test_refill_error();
        refill_log.delete();
        err_addr = 32'h1100;
        push_read(0, 32'h1100, 1'b1);
        drain();
        err_addr = 32'hFFFF_FFFF;
        push_read(0, 32'h1100, 1'b0);
        drain();
        n_checks++;
        if (refill_log.size() != 2 || refill_log[1] !== {1'b0, 32'h1100}) begin
            n_fail++;
            $display("FAIL error_not_allocated: refills=%0d, required 2", refill_log.size());
        end
        push_read(0, 32'h1104, 1'b0);
        drain();
        n_checks++;
        if (refill_log.size() != 2) begin
            n_fail++;
            $display("FAIL error_retry_allocates: refills=%0d, required 2", refill_log.size());
        end
    endtask

    task automatic test_flush();
        refill_log.delete();
        @(negedge clk);
        push_read(0, 32'h1000, 1'b0);
        @(posedge clk);
        #2 flush_valid_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready_o !== '0 || flush_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority: req_ready=%b flush_ready=%0b, required 00 0", req_ready_o, flush_ready_o);
        end
        @(negedge clk);
        n_checks++;
        if (flush_ready_o !== 1'b1 || req_ready_o !== '0) begin
            n_fail++;
            $display("FAIL flush_pulse: flush_ready=%0b req_ready=%b, required 1 00", flush_ready_o, req_ready_o);
        end
        @(posedge clk);
        #1 flush_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flush_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pulse_width: flush_ready=%0b, required 0", flush_ready_o);
        end
        drain();
        n_checks++;
        if (refill_log.size() != 1 || refill_log[0] !== {1'b0, 32'h1000}) begin
            n_fail++;
            $display("FAIL flush_invalidates: refills=%0d, required 1 for 1000", refill_log.size());
        end
    endtask

    task automatic test_alias_backpressure();
        logic [31:0] seq [3] = '{32'h1400, 32'h1000, 32'h1400};
        int          n;
        refill_log.delete();
        for (int i = 0; i < 3; i++) begin
            push_read(0, seq[i], 1'b0);
            drain();
        end
        n_checks++;
        if (refill_log.size() != 3) begin
            n_fail++;
            $display("FAIL alias_refills: refills=%0d, required 3", refill_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (refill_log[i] !== {1'b0, seq[i]}) begin
                    n_fail++;
                    $display("FAIL alias_refill_addr[%0d]: got=%h, required %h", i, refill_log[i], {1'b0, seq[i]});
                end
            end
        end
        refill_log.delete();
        @(posedge clk);
        #1 rsp_ready_i[0] = 1'b0;
        push_read(0, 32'h1004, 1'b0);
        n = 0;
        while (req_q[0].size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        push_read(1, 32'h1008, 1'b0);
        n = 0;
        while (rsp_valid_o[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rsp_valid_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_rsp_timeout: rsp_valid=%b, required 01", rsp_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'hBBBB_BBBB || req_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: rsp_valid=%b data=%h req_ready=%b, required 01 bbbbbbbb 00",
                         i, rsp_valid_o, rsp_data_o, req_ready_o);
            end
        end
        @(posedge clk);
        #1 rsp_ready_i[0] = 1'b1;
        drain();
        n_checks++;
        if (refill_log.size() != 1 || refill_log[0] !== {1'b0, 32'h1000}) begin
            n_fail++;
            $display("FAIL stall_refills: refills=%0d, required 1 for 1000", refill_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_refill_hit();
        test_bypass();
        test_round_robin();
        test_refill_error();
        test_flush();
        test_alias_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
